// File: rtl/dff_shift_chain_pkg.sv
// Shared definitions for the dff_shift_chain delay line / serial-to-parallel buffer.
package dff_shift_chain_pkg;

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_SHIFT  = 2'b01;
  localparam logic [1:0] MODE_LOAD   = 2'b10;
  localparam logic [1:0] MODE_ROTATE = 2'b11;

endpackage

// File: rtl/dff_shift_chain_if.sv
// Control and data bundle for dff_shift_chain; clock and reset stay outside.
interface dff_shift_chain_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SELW  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int unsigned FILLW = $clog2(DEPTH + 1)
);

  logic                     en;
  logic                     sync_clr;
  logic [1:0]               mode;
  logic [WIDTH-1:0]         d;
  logic [WIDTH*DEPTH-1:0]   par_d;
  logic [SELW-1:0]          tap_sel;
  logic [WIDTH-1:0]         q;
  logic [WIDTH-1:0]         tap_q;
  logic [WIDTH*DEPTH-1:0]   all_q;
  logic [FILLW-1:0]         fill;
  logic                     full;

  modport master (
    output en, sync_clr, mode, d, par_d, tap_sel,
    input  q, tap_q, all_q, fill, full
  );

  modport slave (
    input  en, sync_clr, mode, d, par_d, tap_sel,
    output q, tap_q, all_q, fill, full
  );

endinterface

// File: rtl/dff_stage.sv
// One WIDTH-bit register stage: async reset and sync clear both load RESET_VAL.
module dff_stage #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             async_reset,
  input  logic             sync_clr,
  input  logic             en,
  input  logic [WIDTH-1:0] nxt,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      q <= RESET_VAL;
    end else if (sync_clr) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/dff_shift_chain.sv
// WIDTH x DEPTH register chain with hold/shift/load/rotate modes and a fill counter.
module dff_shift_chain
  import dff_shift_chain_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int unsigned      SELW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int unsigned      FILLW     = $clog2(DEPTH + 1)
) (
  input logic              clk,
  input logic              async_reset,
  dff_shift_chain_if.slave bus
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q;
  logic [DEPTH-1:0][WIDTH-1:0] stage_nxt;
  logic [DEPTH-1:0][WIDTH-1:0] shift_src;
  logic [DEPTH-1:0][WIDTH-1:0] rot_src;
  logic [DEPTH-1:0][WIDTH-1:0] par_slices;
  logic                        stage_en;
  logic [FILLW-1:0]            fill_q;
  logic [FILLW-1:0]            fill_d;

  assign par_slices = bus.par_d;
  // HOLD gates the stage enables so the flops simply keep their value.
  assign stage_en   = bus.en && (bus.mode != MODE_HOLD);

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign shift_src[i] = bus.d;
      assign rot_src[i]   = stage_q[DEPTH-1];
    end else begin : g_body
      assign shift_src[i] = stage_q[i-1];
      assign rot_src[i]   = stage_q[i-1];
    end

    dff_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk         (clk),
      .async_reset (async_reset),
      .sync_clr    (bus.sync_clr),
      .en          (stage_en),
      .nxt         (stage_nxt[i]),
      .q           (stage_q[i])
    );
  end

  always_comb begin
    stage_nxt = stage_q;
    case (bus.mode)
      MODE_SHIFT:  stage_nxt = shift_src;
      MODE_LOAD:   stage_nxt = par_slices;
      MODE_ROTATE: stage_nxt = rot_src;
      default:     stage_nxt = stage_q;
    endcase
  end

  always_comb begin
    fill_d = fill_q;
    if (bus.sync_clr) begin
      fill_d = '0;
    end else if (bus.en) begin
      case (bus.mode)
        MODE_SHIFT: begin
          if (fill_q != FILLW'(DEPTH)) begin
            fill_d = fill_q + 1'b1;
          end
        end
        MODE_LOAD: fill_d = FILLW'(DEPTH);
        default:   fill_d = fill_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      fill_q <= '0;
    end else begin
      fill_q <= fill_d;
    end
  end

  assign bus.q     = stage_q[DEPTH-1];
  assign bus.all_q = stage_q;
  assign bus.fill  = fill_q;
  assign bus.full  = (fill_q == FILLW'(DEPTH));
  // Out-of-range selects fall back to RESET_VAL rather than an undefined mux input.
  assign bus.tap_q = (32'(bus.tap_sel) < DEPTH) ? stage_q[bus.tap_sel] : RESET_VAL;

endmodule
